// File: rtl/ocp_pkg.sv
// Shared OCP master definitions: arbiter state encoding, default widths and OCP command/response codes.
package ocp_pkg;

  localparam int unsigned MADDR_WIDTH = 64;
  localparam int unsigned MDATA_WIDTH = 8;
  localparam int unsigned MLEN_WIDTH  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'b00,
    SRESP_DVA  = 2'b01,
    SRESP_FAIL = 2'b10,
    SRESP_ERR  = 2'b11
  } sresp_t;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'b000,
    MCMD_WR   = 3'b001,
    MCMD_RD   = 3'b010
  } mcmd_t;

  // FAIL and ERR both count as an errored beat.
  function automatic logic sresp_is_err(input sresp_t r);
    return (r == SRESP_FAIL) || (r == SRESP_ERR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping, as a one-hot grant.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    rot     = req_dbl[NREQ-1:0];
    first   = rot & (~rot + NREQ'(1));
    gnt_dbl = {first, first} << ptr;
    gnt     = gnt_dbl[2*NREQ-1:NREQ];
  end

  assign any = |req;

endmodule

// File: rtl/ocp_master_arbiter.sv
// Round-robin owner of the shared OCP master FSM: grants one requester per burst, drives the
// FSM request/data ports, counts beats and returns read data and completion status.
module ocp_master_arbiter
  import ocp_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = MADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MDATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = MLEN_WIDTH
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*LEN_WIDTH-1:0]  req_len,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DATA_WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]            wr_pop,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [NREQ-1:0]            rd_valid,
  output logic [NREQ-1:0]            done,
  output logic                       err,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic [LEN_WIDTH-1:0]       burst_length,
  output logic                       read_request,
  output logic                       write_request,
  output logic [DATA_WIDTH-1:0]      write_data,
  input  logic [DATA_WIDTH-1:0]      read_data,
  input  logic                       beat_ack,
  input  logic                       resp_valid,
  input  logic                       resp_err
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t            state_q, state_d;
  logic [GW-1:0]         gnt_q, gnt_d, ptr_q, ptr_d, arb_idx;
  logic [NREQ-1:0]       arb_gnt, gnt_oh;
  logic                  arb_any;
  logic                  is_wr_q, is_wr_d, sticky_q, sticky_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, sel_len, eff_len, blen_d;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [NREQ-1:0]       req_ready_d, wr_pop_d, rd_valid_d, done_d;
  logic                  err_d, rreq_d, wreq_d;

  rr_arbiter #(.NREQ(NREQ), .PW(GW)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // One-hot grant to index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt[i]) arb_idx = GW'(i);
    end
  end

  assign sel_len   = req_len[arb_idx*LEN_WIDTH +: LEN_WIDTH];
  assign eff_len   = (sel_len == '0) ? LEN_WIDTH'(1) : sel_len;
  assign gnt_oh    = NREQ'(1) << gnt_q;
  // burst_length holds the effective length L for the whole transaction.
  assign last_beat = (cnt_q == burst_length - LEN_WIDTH'(1));

  assign write_data = ((state_q == ST_WDATA) || (state_q == ST_ISSUE && is_wr_q))
                    ? wr_data[gnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    is_wr_d     = is_wr_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    address_d   = address;
    blen_d      = burst_length;
    rd_data_d   = rd_data;
    req_ready_d = '0;
    wr_pop_d    = '0;
    rd_valid_d  = '0;
    done_d      = '0;
    err_d       = 1'b0;
    rreq_d      = 1'b0;
    wreq_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d       = arb_idx;
          is_wr_d     = req_write[arb_idx];
          address_d   = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          blen_d      = eff_len;
          req_ready_d = arb_gnt;
          wreq_d      = req_write[arb_idx];
          rreq_d      = ~req_write[arb_idx];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d    = '0;
        sticky_d = 1'b0;
        state_d  = is_wr_q ? ST_WDATA : ST_RDATA;
      end
      ST_WDATA: begin
        if (beat_ack) begin
          wr_pop_d = gnt_oh;
          cnt_d    = cnt_q + LEN_WIDTH'(1);
          sticky_d = sticky_q | resp_err;
          if (last_beat) begin
            done_d  = gnt_oh;
            err_d   = sticky_q | resp_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_RDATA: begin
        if (resp_valid) begin
          rd_data_d  = read_data;
          rd_valid_d = gnt_oh;
          cnt_d      = cnt_q + LEN_WIDTH'(1);
          sticky_d   = sticky_q | resp_err;
          if (last_beat) begin
            done_d  = gnt_oh;
            err_d   = sticky_q | resp_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        ptr_d   = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      ptr_q         <= '0;
      is_wr_q       <= 1'b0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      address       <= '0;
      burst_length  <= '0;
      rd_data       <= '0;
      req_ready     <= '0;
      wr_pop        <= '0;
      rd_valid      <= '0;
      done          <= '0;
      err           <= 1'b0;
      read_request  <= 1'b0;
      write_request <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ptr_q         <= ptr_d;
      is_wr_q       <= is_wr_d;
      sticky_q      <= sticky_d;
      cnt_q         <= cnt_d;
      address       <= address_d;
      burst_length  <= blen_d;
      rd_data       <= rd_data_d;
      req_ready     <= req_ready_d;
      wr_pop        <= wr_pop_d;
      rd_valid      <= rd_valid_d;
      done          <= done_d;
      err           <= err_d;
      read_request  <= rreq_d;
      write_request <= wreq_d;
    end
  end

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// Directed bench for ocp_master_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_ocp_master_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 10;

  logic            sys_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    req_ready, wr_pop, rd_valid, done;
  logic [N*DW-1:0] wr_data = '0;
  logic [DW-1:0]   rd_data, write_data;
  logic [DW-1:0]   read_data = '0;
  logic            err, read_request, write_request;
  logic [AW-1:0]   address;
  logic [LW-1:0]   burst_length;
  logic            beat_ack = 1'b0, resp_valid = 1'b0, resp_err = 1'b0;

  always #5 sys_clk = ~sys_clk;

  ocp_master_arbiter #(.NREQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .address(address), .burst_length(burst_length),
    .read_request(read_request), .write_request(write_request), .write_data(write_data),
    .read_data(read_data), .beat_ack(beat_ack), .resp_valid(resp_valid), .resp_err(resp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: describes the cycle in progress after each clock edge.
  bit            m_free = 1'b1, m_issue = 1'b0, m_tail = 1'b0, m_wr = 1'b0, m_bad = 1'b0;
  int            m_owner = -1, m_last = int'(N) - 1, m_len = 0, m_got = 0, m_pick = -1, m_c = 0;
  logic [N-1:0]  e_ready = '0, e_wpop = '0, e_rvalid = '0, e_done = '0;
  logic          e_err = 1'b0, e_rq = 1'b0, e_wq = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [LW-1:0] e_blen = '0, m_rawlen = '0;
  logic [DW-1:0] e_rdata = '0;

  initial forever begin
    @(posedge sys_clk or negedge reset_n);
    if (!reset_n) begin
      m_free = 1'b1; m_issue = 1'b0; m_tail = 1'b0; m_owner = -1; m_last = int'(N) - 1;
      e_ready = '0; e_wpop = '0; e_rvalid = '0; e_done = '0; e_err = 1'b0;
      e_rq = 1'b0; e_wq = 1'b0; e_addr = '0; e_blen = '0; e_rdata = '0;
    end else begin
      e_ready = '0; e_wpop = '0; e_rvalid = '0; e_done = '0; e_err = 1'b0; e_rq = 1'b0; e_wq = 1'b0;
      if (m_free) begin
        m_pick = -1;
        for (int s = 1; s <= int'(N); s++) begin
          m_c = (m_last + s) % int'(N);
          if (m_pick < 0 && req_valid[m_c]) m_pick = m_c;
        end
        if (m_pick >= 0) begin
          m_owner  = m_pick;
          m_last   = m_pick;
          m_wr     = req_write[m_pick];
          m_rawlen = req_len[m_pick*LW +: LW];
          m_len    = (m_rawlen == 0) ? 1 : int'(m_rawlen);
          m_got    = 0;
          m_bad    = 1'b0;
          e_addr   = req_addr[m_pick*AW +: AW];
          e_blen   = LW'(m_len);
          e_ready[m_pick] = 1'b1;
          e_wq     = m_wr;
          e_rq     = !m_wr;
          m_free   = 1'b0;
          m_issue  = 1'b1;
        end
      end else if (m_issue) begin
        m_issue = 1'b0;
      end else if (m_tail) begin
        m_tail  = 1'b0;
        m_free  = 1'b1;
        m_owner = -1;
      end else if (m_wr ? beat_ack : resp_valid) begin
        m_got++;
        m_bad = m_bad | resp_err;
        if (m_wr) e_wpop[m_owner] = 1'b1;
        else begin
          e_rvalid[m_owner] = 1'b1;
          e_rdata = read_data;
        end
        if (m_got == m_len) begin
          e_done[m_owner] = 1'b1;
          e_err  = m_bad;
          m_tail = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (reset_n) begin
      cmp("req_ready", 64'(req_ready), 64'(e_ready));
      cmp("wr_pop", 64'(wr_pop), 64'(e_wpop));
      cmp("rd_valid", 64'(rd_valid), 64'(e_rvalid));
      cmp("done", 64'(done), 64'(e_done));
      cmp("read_request", 64'(read_request), 64'(e_rq));
      cmp("write_request", 64'(write_request), 64'(e_wq));
      if (e_done != '0) cmp("err", 64'(err), 64'(e_err));
      if (e_rvalid != '0) cmp("rd_data", 64'(rd_data), 64'(e_rdata));
      if (!m_free) begin
        cmp("address", address, e_addr);
        cmp("burst_length", 64'(burst_length), 64'(e_blen));
      end
      if (m_free) cmp("write_data_idle", 64'(write_data), 64'd0);
      else if (m_owner >= 0 && !m_issue && !m_tail && m_wr)
        cmp("write_data", 64'(write_data), 64'(wr_data[m_owner*DW +: DW]));
    end
  end

  logic [7:0] beat_val [8];

  task automatic set_req(input int i, input bit wr, input logic [63:0] a, input logic [9:0] l);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW] = l;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int c = 0; c < 40 && who < 0; c++) begin
      @(negedge sys_clk);
      for (int i = 0; i < int'(N); i++) if (req_ready[i]) who = i;
    end
    if (who < 0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: got no req_ready expected one within 40 cycles at %0t", $time);
    end
  endtask

  // Deliver n beats (one every other cycle plus gap idles); returns done/err seen after the last beat.
  task automatic serve(input int who, input bit wr, input int n, input int errbeat, input int gap,
                       output logic dn, output logic er, output logic [7:0] wd0);
    dn = 1'b0; er = 1'b0; wd0 = '0;
    if (who >= 0) begin
      for (int k = 0; k < n; k++) begin
        repeat (gap) @(negedge sys_clk);
        @(negedge sys_clk);
        if (wr) begin
          wr_data[who*DW +: DW] = beat_val[k];
          beat_ack = 1'b1;
        end else begin
          read_data  = beat_val[k];
          resp_valid = 1'b1;
        end
        resp_err = (k == errbeat);
        if (k == 0) begin
          #1;
          wd0 = write_data;
        end
        @(negedge sys_clk);
        beat_ack = 1'b0; resp_valid = 1'b0; resp_err = 1'b0;
      end
      dn = done[who];
      er = err;
    end
  endtask

  int         who;
  int         order [4];
  logic       dn, er;
  logic [7:0] wd0;

  initial begin
    repeat (3) @(negedge sys_clk);
    cmp("rst_req_ready", 64'(req_ready), 64'd0);
    cmp("rst_done", 64'(done), 64'd0);
    cmp("rst_address", address, 64'd0);
    cmp("rst_burst_length", 64'(burst_length), 64'd0);
    cmp("rst_rd_data", 64'(rd_data), 64'd0);
    cmp("rst_err", 64'(err), 64'd0);
    reset_n = 1'b1;
    @(negedge sys_clk);

    // Single write, len 1, data 0xFF
    set_req(0, 1'b1, 64'hFF, 10'd1);
    beat_val[0] = 8'hFF;
    wait_grant(who);
    cmp("t1_grant", 64'(who), 64'd0);
    cmp("t1_write_request", 64'(write_request), 64'd1);
    cmp("t1_address", address, 64'hFF);
    req_valid[0] = 1'b0;
    serve(who, 1'b1, 1, -1, 0, dn, er, wd0);
    cmp("t1_write_data", 64'(wd0), 64'hFF);
    cmp("t1_wr_pop", 64'(wr_pop), 64'b01);
    cmp("t1_done", 64'(dn), 64'd1);
    cmp("t1_err", 64'(er), 64'd0);

    // Read burst len 4 on requester 1 with gaps
    set_req(1, 1'b0, 64'h1000, 10'd4);
    beat_val[0] = 8'h04; beat_val[1] = 8'h08; beat_val[2] = 8'h0C; beat_val[3] = 8'h20;
    wait_grant(who);
    cmp("t2_grant", 64'(who), 64'd1);
    cmp("t2_read_request", 64'(read_request), 64'd1);
    req_valid[1] = 1'b0;
    serve(who, 1'b0, 4, -1, 1, dn, er, wd0);
    cmp("t2_done", 64'(dn), 64'd1);
    cmp("t2_rd_valid", 64'(rd_valid), 64'b10);
    cmp("t2_rd_data", 64'(rd_data), 64'h20);

    // Contention after reset: both held, expect 0,1,0,1
    reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    set_req(0, 1'b0, 64'hA0, 10'd1);
    set_req(1, 1'b0, 64'hB0, 10'd2);
    beat_val[0] = 8'h5A; beat_val[1] = 8'hA5;
    for (int t = 0; t < 4; t++) begin
      wait_grant(who);
      order[t] = who;
      serve(who, 1'b0, (who == 1) ? 2 : 1, -1, 0, dn, er, wd0);
    end
    req_valid = '0;
    cmp("t3_order0", 64'(order[0]), 64'd0);
    cmp("t3_order1", 64'(order[1]), 64'd1);
    cmp("t3_order2", 64'(order[2]), 64'd0);
    cmp("t3_order3", 64'(order[3]), 64'd1);

    // Error on second of three read beats, then a clean transaction
    set_req(0, 1'b0, 64'h2000, 10'd3);
    beat_val[0] = 8'h11; beat_val[1] = 8'h22; beat_val[2] = 8'h33;
    wait_grant(who);
    req_valid[0] = 1'b0;
    serve(who, 1'b0, 3, 1, 0, dn, er, wd0);
    cmp("t4_done", 64'(dn), 64'd1);
    cmp("t4_err", 64'(er), 64'd1);
    cmp("t4_rd_data", 64'(rd_data), 64'h33);
    set_req(1, 1'b0, 64'h3000, 10'd2);
    wait_grant(who);
    req_valid[1] = 1'b0;
    serve(who, 1'b0, 2, -1, 0, dn, er, wd0);
    cmp("t4_next_done", 64'(dn), 64'd1);
    cmp("t4_next_err", 64'(er), 64'd0);

    // req_len 0 behaves as 1; stray beats in IDLE are ignored
    set_req(0, 1'b1, 64'h40, 10'd0);
    beat_val[0] = 8'h77;
    wait_grant(who);
    cmp("t5_burst_length", 64'(burst_length), 64'd1);
    req_valid[0] = 1'b0;
    serve(who, 1'b1, 1, -1, 0, dn, er, wd0);
    cmp("t5_done", 64'(dn), 64'd1);
    @(negedge sys_clk);
    beat_ack = 1'b1; resp_valid = 1'b1;
    @(negedge sys_clk);
    beat_ack = 1'b0; resp_valid = 1'b0;
    cmp("t5_idle_wr_pop", 64'(wr_pop), 64'd0);
    cmp("t5_idle_rd_valid", 64'(rd_valid), 64'd0);

    // Reset after 2 of 5 write beats
    set_req(0, 1'b1, 64'h5000, 10'd5);
    beat_val[0] = 8'h01; beat_val[1] = 8'h02;
    wait_grant(who);
    req_valid[0] = 1'b0;
    serve(who, 1'b1, 2, -1, 0, dn, er, wd0);
    cmp("t6_no_done_mid", 64'(dn), 64'd0);
    reset_n = 1'b0;
    #1;
    cmp("t6_req_ready", 64'(req_ready), 64'd0);
    cmp("t6_wr_pop", 64'(wr_pop), 64'd0);
    cmp("t6_done", 64'(done), 64'd0);
    cmp("t6_address", address, 64'd0);
    cmp("t6_burst_length", 64'(burst_length), 64'd0);
    cmp("t6_rd_data", 64'(rd_data), 64'd0);
    cmp("t6_write_request", 64'(write_request), 64'd0);
    cmp("t6_write_data", 64'(write_data), 64'd0);
    set_req(1, 1'b1, 64'h6000, 10'd2);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    wait_grant(who);
    cmp("t6_regrant", 64'(who), 64'd1);
    req_valid[1] = 1'b0;
    beat_val[0] = 8'hC1; beat_val[1] = 8'hC2;
    serve(who, 1'b1, 2, -1, 0, dn, er, wd0);
    cmp("t6_after_done", 64'(dn), 64'd1);
    cmp("t6_after_err", 64'(er), 64'd0);

    repeat (4) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ocp_master_arbiter.md
# ocp_master_arbiter

Round-robin scheduler that shares the single OCP master FSM between up to four bridge-side requesters, e.g. the PCIe posted-write path and the read-completion path. It grants one requester at a time and holds the grant for the whole burst. It drives the FSM's bridge-side request and data ports, counts data beats, and returns read data and completion status to the owning requester. It sits between the bridge request queues and `ocp_master_fsm`.

## Interface
- `NREQ`, default 2: number of requesters, 1..4.
- `ADDR_WIDTH`, default 64: address width, matches `MADDR_WIDTH`.
- `DATA_WIDTH`, default 8: data width, matches `MDATA_WIDTH`.
- `LEN_WIDTH`, default 10: burst length width.

- `sys_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a pending transaction.
- `req_write`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*ADDR_WIDTH  start address per requester.
- `req_len`  in  NREQ*LEN_WIDTH  burst length in beats; 0 is treated as 1.
- `req_ready`  out  NREQ  one-hot, one-cycle pulse: request accepted.
- `wr_data`  in  NREQ*DATA_WIDTH  current write beat per requester.
- `wr_pop`  out  NREQ  one-hot pulse: write beat consumed, present the next one.
- `rd_data`  out  DATA_WIDTH  read beat.
- `rd_valid`  out  NREQ  one-hot: `rd_data` valid for requester i.
- `done`  out  NREQ  one-hot, one-cycle pulse: transaction complete.
- `err`  out  1  valid with `done`: one or more beats returned FAIL or ERR.
- `address`  out  ADDR_WIDTH  to FSM.
- `burst_length`  out  LEN_WIDTH  to FSM.
- `read_request`  out  1  to FSM.
- `write_request`  out  1  to FSM.
- `write_data`  out  DATA_WIDTH  to FSM.
- `read_data`  in  DATA_WIDTH  from FSM.
- `beat_ack`  in  1  FSM consumed the write beat this cycle.
- `resp_valid`  in  1  FSM read beat valid (SResp != NULL).
- `resp_err`  in  1  qualifies `resp_valid`/`beat_ack`: SResp is FAIL or ERR.

## Operation
- States: IDLE, ISSUE, WDATA, RDATA, DONE.
- IDLE: if any `req_valid`, pick the first requester at or after `rr_ptr` (wrapping) and latch grant `g`, `req_write[g]`, `req_addr[g]`, and effective length L = max(`req_len[g]`, 1). Then go to ISSUE.
- ISSUE (1 cycle):
  - pulse `req_ready[g]`;
  - drive `address` and `burst_length` = L;
  - assert `write_request` or `read_request` for exactly this cycle;
  - clear the beat counter `cnt` and the sticky error;
  - go to WDATA or RDATA.
- WDATA:
  - `write_data` = `wr_data[g]` (combinational).
  - On `beat_ack`: pulse `wr_pop[g]` and increment `cnt`.
  - When `beat_ack` arrives with `cnt` == L-1, go to DONE.
- RDATA:
  - On `resp_valid`: `rd_data` = `read_data` (registered), pulse `rd_valid[g]`, increment `cnt`.
  - When `resp_valid` arrives with `cnt` == L-1, go to DONE.
- Error: `resp_err`, when qualified, sets the sticky error. The transaction still runs to L beats; there is no early abort.
- DONE (1 cycle): pulse `done[g]` with `err` = sticky error; set `rr_ptr` = g+1 mod NREQ; go to IDLE.
- `address` and `burst_length` stay stable from ISSUE through DONE.
- `req_valid` deassertion after grant is ignored: a granted transaction always completes.
- `cnt` is LEN_WIDTH bits; L=1023 reaches `cnt`=1022 without wrap.

## Timing
- Reset (async assert, sync release): state IDLE, `rr_ptr`=0. All outputs are 0, including `address`, `burst_length`, `rd_data`, `err`.
- Grant latency: `req_valid` sampled in IDLE at edge k gives `req_ready` and `*_request` high in cycle k+1.
- Read beat latency: `rd_valid` asserts one cycle after `resp_valid`.
- `wr_pop` is registered, one cycle after `beat_ack`. The FSM must not ack the next beat in the cycle immediately after an ack; the FSM contract guarantees this.
- Turnaround: minimum gap between consecutive `req_ready` pulses is L+3 cycles.
- Beats outside WDATA/RDATA: `resp_valid` or `beat_ack` in IDLE, ISSUE or DONE is ignored.
- Reset mid-burst: immediate abort; no `done` pulse is emitted.
- Single requester active: it is re-granted every transaction; the pointer wrap is harmless.

## Structure
- Shared `ocp_pkg`: state encoding, width defaults, SResp codes (NULL/DVA/FAIL/ERR), MCmd codes.
- Sub-module `rr_arbiter` (NREQ): inputs `req`, `ptr`; outputs one-hot `gnt` and `any`. Purely combinational priority-rotate.

## Test plan
- Single write: req0 write, addr 0xFF, len 1, data 0xFF. Expect `req_ready[0]` and `write_request` in the same cycle, `write_data`=0xFF, then `wr_pop[0]` after `beat_ack`, then `done[0]`, `err`=0.
- Read burst: req1 read, len 4, FSM returns 0x04, 0x08, 0x0C, 0x20 with gaps. Expect 4 `rd_valid[1]` pulses with matching data, then `done[1]` the cycle after the 4th beat.
- Contention: both `req_valid` held after reset. Expect grant order 0, 1, 0, 1 and never overlapping grants.
- Error: read len 3, second beat `resp_err`=1. Expect all 3 beats delivered and `done` with `err`=1. The next transaction reports `err`=0.
- Boundary: `req_len`=0 behaves as len 1. `beat_ack` asserted during IDLE causes no `wr_pop`.
- Reset: assert `reset_n`=0 mid write burst (after 2 of 5 beats). Expect all outputs 0 immediately and no `done`. After release, req1 pending alone is granted first.
